// File: rtl/id_ex_pkg.sv
// Shared widths, NOP encodings, payload layout and FSM states for the ID->EX pipe.
// The optional ID_EX_SKID_BUF_EN build uses ST_FULL_SKID; the base build never enters it.
package id_ex_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int ALUOP_W_DEF  = 7;
  localparam int ALUSEL_W_DEF = 3;
  localparam int REG_AW_DEF   = 5;
  localparam int CNT_W_DEF    = 16;

  localparam logic [ALUOP_W_DEF-1:0]  ALUOP_NOP  = '0;
  localparam logic [ALUSEL_W_DEF-1:0] ALUSEL_NOP = '0;

  localparam int PAYLOAD_W = ALUOP_W_DEF + ALUSEL_W_DEF + 3*XLEN_DEF + REG_AW_DEF + 1;

  // Field order matches the concatenation used in id_ex_pipe (MSB first).
  typedef struct packed {
    logic [ALUOP_W_DEF-1:0]  aluop;
    logic [ALUSEL_W_DEF-1:0] alusel;
    logic [XLEN_DEF-1:0]     reg1;
    logic [XLEN_DEF-1:0]     reg2;
    logic [XLEN_DEF-1:0]     reg_last;
    logic [REG_AW_DEF-1:0]   wd;
    logic                    wreg;
  } id_ex_payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_FULL_SKID = 2'd2
  } pipe_state_e;

  function automatic int payload_width(input int xlen, input int aluop_w,
                                       input int alusel_w, input int reg_aw);
    return aluop_w + alusel_w + 3*xlen + reg_aw + 1;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with synchronous flush.
// Defining ID_EX_SKID_BUF_EN adds a one-entry skid so up_ready comes from a flop.
//
// state        | meaning
// ST_EMPTY     | no payload held, dn_valid=0, output zeroed
// ST_FULL      | output register holds the oldest payload
// ST_FULL_SKID | output and skid both hold payloads (skid build only)
module pipe_skid_buf
  import id_ex_pkg::*;
#(
  parameter int W = PAYLOAD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  pipe_state_e state_q, state_d;
  logic        up_acc;
  logic        dn_take;
  logic        load_out;
  logic        clear_out;

`ifdef ID_EX_SKID_BUF_EN
  logic         ready_q;
  logic [W-1:0] skid_q;
  logic         load_skid;
  logic         skid_to_out;
  logic         clear_skid;

  assign up_ready = ready_q;
`else
  assign up_ready = (state_q == ST_EMPTY) | dn_ready;
`endif

  assign dn_valid = (state_q != ST_EMPTY);
  assign up_acc   = up_valid & up_ready;
  assign dn_take  = dn_valid & dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    clear_out = 1'b0;
`ifdef ID_EX_SKID_BUF_EN
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    clear_skid  = 1'b0;
`endif
    if (flush) begin
      state_d   = ST_EMPTY;
      clear_out = 1'b1;
`ifdef ID_EX_SKID_BUF_EN
      clear_skid = 1'b1;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_acc) begin
            state_d  = ST_FULL;
            load_out = 1'b1;
          end
        end
        ST_FULL: begin
          if (dn_take && up_acc) begin
            load_out = 1'b1;
          end else if (dn_take) begin
            state_d   = ST_EMPTY;
            clear_out = 1'b1;
          end
`ifdef ID_EX_SKID_BUF_EN
          else if (up_acc) begin
            state_d   = ST_FULL_SKID;
            load_skid = 1'b1;
          end
`endif
        end
`ifdef ID_EX_SKID_BUF_EN
        ST_FULL_SKID: begin
          // up_ready is low here, so the only move is draining the skid forward.
          if (dn_take) begin
            state_d     = ST_FULL;
            skid_to_out = 1'b1;
            clear_skid  = 1'b1;
          end
        end
`endif
        default: begin
          state_d   = ST_EMPTY;
          clear_out = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          dn_data <= '0;
    else if (clear_out)  dn_data <= '0;
    else if (load_out)   dn_data <= up_data;
`ifdef ID_EX_SKID_BUF_EN
    else if (skid_to_out) dn_data <= skid_q;
`endif
  end

`ifdef ID_EX_SKID_BUF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          skid_q <= '0;
    else if (clear_skid) skid_q <= '0;
    else if (load_skid)  skid_q <= up_data;
  end

  // Registered ready: high exactly when the skid will be empty next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b1;
    else        ready_q <= (state_d != ST_FULL_SKID);
  end
`endif

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register: payload packing, bubble gating and saturating stall counter.
// Define ID_EX_SKID_BUF_EN to add a one-entry skid buffer with a registered id_ready.
module id_ex_pipe
  import id_ex_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ALUOP_W  = ALUOP_W_DEF,
  parameter int ALUSEL_W = ALUSEL_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [XLEN-1:0]     id_reg1,
  input  logic [XLEN-1:0]     id_reg2,
  input  logic [XLEN-1:0]     id_reg_last,
  input  logic [REG_AW-1:0]   id_wd,
  input  logic                id_wreg,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [XLEN-1:0]     ex_reg1,
  output logic [XLEN-1:0]     ex_reg2,
  output logic [XLEN-1:0]     ex_reg_last,
  output logic [REG_AW-1:0]   ex_wd,
  output logic                ex_wreg,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int PW = payload_width(XLEN, ALUOP_W, ALUSEL_W, REG_AW);

  logic [PW-1:0]       id_payload;
  logic [PW-1:0]       ex_payload;
  logic [ALUOP_W-1:0]  pl_aluop;
  logic [ALUSEL_W-1:0] pl_alusel;
  logic                pl_wreg;

  assign id_payload = {id_aluop, id_alusel, id_reg1, id_reg2, id_reg_last, id_wd, id_wreg};

  pipe_skid_buf #(
    .W (PW)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .up_valid (id_valid),
    .up_ready (id_ready),
    .up_data  (id_payload),
    .dn_valid (ex_valid),
    .dn_ready (ex_ready),
    .dn_data  (ex_payload)
  );

  assign {pl_aluop, pl_alusel, ex_reg1, ex_reg2, ex_reg_last, ex_wd, pl_wreg} = ex_payload;

  // Buffer already zeroes empty entries; the gating makes the bubble rule explicit at the port.
  assign ex_aluop  = ex_valid ? pl_aluop  : ALUOP_W'(ALUOP_NOP);
  assign ex_alusel = ex_valid ? pl_alusel : ALUSEL_W'(ALUSEL_NOP);
  assign ex_wreg   = ex_valid & pl_wreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (ex_valid && !ex_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: queue-based reference model plus directed literal checks.
// Expectations follow ID_EX_SKID_BUF_EN when it is defined for the build.
module tb_id_ex_pipe;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ID_EX_SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] reg_last;
    logic [4:0]  wd;
    logic        wreg;
  } pl_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             id_valid = 1'b0;
  logic             id_ready;
  logic [6:0]       id_aluop = '0;
  logic [2:0]       id_alusel = '0;
  logic [31:0]      id_reg1 = '0;
  logic [31:0]      id_reg2 = '0;
  logic [31:0]      id_reg_last = '0;
  logic [4:0]       id_wd = '0;
  logic             id_wreg = 1'b0;
  logic             ex_valid;
  logic             ex_ready = 1'b1;
  logic [6:0]       ex_aluop;
  logic [2:0]       ex_alusel;
  logic [31:0]      ex_reg1;
  logic [31:0]      ex_reg2;
  logic [31:0]      ex_reg_last;
  logic [4:0]       ex_wd;
  logic             ex_wreg;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pl_t m_q[$];
  int  m_cnt = 0;

  id_ex_pipe #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_aluop    (id_aluop),
    .id_alusel   (id_alusel),
    .id_reg1     (id_reg1),
    .id_reg2     (id_reg2),
    .id_reg_last (id_reg_last),
    .id_wd       (id_wd),
    .id_wreg     (id_wreg),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_aluop    (ex_aluop),
    .ex_alusel   (ex_alusel),
    .ex_reg1     (ex_reg1),
    .ex_reg2     (ex_reg2),
    .ex_reg_last (ex_reg_last),
    .ex_wd       (ex_wd),
    .ex_wreg     (ex_wreg),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_ready();
    if (SKID) return m_q.size() < 2;
    return (m_q.size() == 0) || ex_ready;
  endfunction

  function automatic pl_t cur_in();
    pl_t p;
    p.aluop = id_aluop; p.alusel = id_alusel; p.reg1 = id_reg1; p.reg2 = id_reg2;
    p.reg_last = id_reg_last; p.wd = id_wd; p.wreg = id_wreg;
    return p;
  endfunction

  // Reference model: a FIFO of accepted instructions, head presented to EX.
  always @(posedge clk or negedge rst_n) begin : model
    bit acc;
    bit take;
    if (!rst_n) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      acc  = id_valid && m_ready();
      take = (m_q.size() > 0) && ex_ready;
      if ((m_q.size() > 0) && !ex_ready && (m_cnt < CNT_MAX)) m_cnt++;
      if (flush) begin
        m_q.delete();
      end else begin
        if (take) void'(m_q.pop_front());
        if (acc)  m_q.push_back(cur_in());
      end
    end
  end

  always @(negedge clk) begin : compare
    pl_t act;
    pl_t exp;
    act = {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_reg_last, ex_wd, ex_wreg};
    exp = (m_q.size() > 0) ? m_q[0] : '0;
    chk("ex_valid", 128'(ex_valid), 128'(m_q.size() > 0));
    chk("payload", 128'(act), 128'(exp));
    chk("id_ready", 128'(id_ready), 128'(m_ready()));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(2);
    chk("rst_ex_valid", 128'(ex_valid), 128'(0));
    chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    chk("rst_id_ready", 128'(id_ready), 128'(1));
    rst_n = 1'b1;
    step(1);

    // Streaming at one per cycle
    ex_ready = 1'b1; id_aluop = 7'h13; id_wd = 5'd3; id_wreg = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      id_valid = 1'b1; id_reg1 = 32'(i);
      step(1);
      chk("stream_reg1", 128'(ex_reg1), 128'(i));
      chk("stream_id_ready", 128'(id_ready), 128'(1));
    end
    id_valid = 1'b0;
    step(1);
    chk("bubble_valid", 128'(ex_valid), 128'(0));
    chk("bubble_aluop", 128'(ex_aluop), 128'(0));
    chk("bubble_wreg", 128'(ex_wreg), 128'(0));

    // Back-pressure
    id_valid = 1'b1; id_reg1 = 32'h55; id_reg2 = 32'h0; ex_ready = 1'b0;
    step(1);
    id_reg1 = 32'h0; id_reg2 = 32'h66;
    step(4);
    chk("bp_hold_reg1", 128'(ex_reg1), 128'h55);
    chk("bp_id_ready", 128'(id_ready), 128'(0));
    chk("bp_stall_cnt", 128'(stall_cnt), 128'(4));
    id_valid = 1'b0; ex_ready = 1'b1;
    step(1);
`ifdef ID_EX_SKID_BUF_EN
    chk("skid_order_valid", 128'(ex_valid), 128'(1));
    chk("skid_order_reg2", 128'(ex_reg2), 128'h66);
    step(1);
`endif
    chk("bp_drained", 128'(ex_valid), 128'(0));

    // Flush beats a simultaneous accept and consume
    id_valid = 1'b1; id_reg1 = 32'd9; id_reg2 = 32'd0; id_wd = 5'd7; id_wreg = 1'b1;
    step(1);
    flush = 1'b1;
    step(1);
    chk("flush_valid", 128'(ex_valid), 128'(0));
    chk("flush_wreg", 128'(ex_wreg), 128'(0));
    chk("flush_wd", 128'(ex_wd), 128'(0));
    flush = 1'b0; id_valid = 1'b0; id_wd = 5'd0; id_wreg = 1'b0;

    // Saturation: 4 + 20 stall cycles clamps at 15, flush leaves it alone
    id_valid = 1'b1; id_reg1 = 32'hAA; ex_ready = 1'b0;
    step(1);
    id_valid = 1'b0;
    step(20);
    chk("sat_stall_cnt", 128'(stall_cnt), 128'(15));
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("sat_after_flush", 128'(stall_cnt), 128'(15));
    chk("sat_flush_valid", 128'(ex_valid), 128'(0));

    // Asynchronous reset between edges
    id_valid = 1'b1; id_reg1 = 32'hDEADBEEF;
    step(1);
    id_valid = 1'b0;
    chk("pre_rst_reg1", 128'(ex_reg1), 128'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(ex_valid), 128'(0));
    chk("async_rst_reg1", 128'(ex_reg1), 128'(0));
    chk("async_rst_cnt", 128'(stall_cnt), 128'(0));
    step(1);
    rst_n = 1'b1; ex_ready = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
